// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver; mid-bit sampling, one-cycle valid/frame-error
//            strobes, break-line recovery through a wait-for-idle state.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int          c_BIT_DIV   = CLK_FREQ / BAUD;
    localparam int          c_HALF_DIV  = c_BIT_DIV / 2;
    localparam logic [12:0] c_BIT_LAST  = 13'(c_BIT_DIV - 1);
    localparam logic [12:0] c_HALF_LAST = 13'(c_HALF_DIV - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_STOP      = 3'd3;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd4;

    logic [2:0]  r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_s_d;
    logic [12:0] r_bit_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_fall;

    assign w_fall = r_rx_s_d & ~r_rx_s;

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
            r_bit_cnt <= 13'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    busy <= 1'b0;
                    if (w_fall) begin
                        r_state   <= c_ST_START;
                        r_bit_cnt <= 13'd0;
                        busy      <= 1'b1;
                    end
                end

                // A line that is high again at start-bit centre was only a glitch.
                c_ST_START: begin
                    if (r_bit_cnt == c_HALF_LAST) begin
                        r_bit_cnt <= 13'd0;
                        if (r_rx_s) begin
                            r_state <= c_ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state   <= c_ST_DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 13'd1;
                    end
                end

                c_ST_DATA: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_cnt          <= 13'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 13'd1;
                    end
                end

                // Leaving at mid-stop keeps the next start edge catchable.
                c_ST_STOP: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= 13'd0;
                        if (r_rx_s) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            r_state  <= c_ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= c_ST_WAIT_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 13'd1;
                    end
                end

                c_ST_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= c_ST_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_byte
// Brief    : Directed self-checking bench for uart_rx_byte (fast-baud and
//            default-baud instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int c_PERIOD = 20;

    logic       sclk;
    logic       r_rst;
    logic       r_rx0;
    logic       r_rx1;
    logic [7:0] w_rx_data0;
    logic       w_rx_valid0;
    logic       w_frame_err0;
    logic       w_busy0;
    logic [7:0] w_rx_data1;
    logic       w_rx_valid1;
    logic       w_frame_err1;
    logic       w_busy1;

    int r_n_checks = 0;
    int r_n_pass   = 0;

    int         r_v_cnt0 = 0, r_f_cnt0 = 0, r_busy_cyc0 = 0;
    int         r_v_cnt1 = 0, r_f_cnt1 = 0;
    int         r_both   = 0;
    time        r_v_time0 = 0;
    logic [7:0] r_q0[$];
    logic [7:0] r_q1[$];

    uart_rx_byte #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) u_dut_fast (
        .sclk      (sclk),
        .rst       (r_rst),
        .rx        (r_rx0),
        .rx_data   (w_rx_data0),
        .rx_valid  (w_rx_valid0),
        .frame_err (w_frame_err0),
        .busy      (w_busy0)
    );

    uart_rx_byte u_dut_dflt (
        .sclk      (sclk),
        .rst       (r_rst),
        .rx        (r_rx1),
        .rx_data   (w_rx_data1),
        .rx_valid  (w_rx_valid1),
        .frame_err (w_frame_err1),
        .busy      (w_busy1)
    );

    initial sclk = 1'b0;
    always #(c_PERIOD / 2) sclk = ~sclk;

    always @(negedge sclk) begin
        if (w_rx_valid0) begin
            r_v_cnt0++;
            r_q0.push_back(w_rx_data0);
            r_v_time0 = $time;
        end
        if (w_frame_err0) r_f_cnt0++;
        if (w_busy0) r_busy_cyc0++;
        if (w_rx_valid1) begin
            r_v_cnt1++;
            r_q1.push_back(w_rx_data1);
        end
        if (w_frame_err1) r_f_cnt1++;
        if ((w_rx_valid0 && w_frame_err0) || (w_rx_valid1 && w_frame_err1)) r_both++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_n_checks++;
        if (got === exp) r_n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_bit(input int line, input logic val, input int cyc);
        if (line == 0) r_rx0 = val;
        else           r_rx1 = val;
        repeat (cyc) @(negedge sclk);
    endtask

    task automatic send_frame(input int line, input logic [7:0] b, input int cyc, input logic stop_val);
        drive_bit(line, 1'b0, cyc);
        for (int i = 0; i < 8; i++) drive_bit(line, b[i], cyc);
        drive_bit(line, stop_val, cyc);
    endtask

    initial begin
        #(c_PERIOD * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  v0, f0, b0, q0n, v1, f1;
        time t0;

        r_rst = 1'b1;
        r_rx0 = 1'b1;
        r_rx1 = 1'b1;
        repeat (4) @(negedge sclk);
        r_rst = 1'b0;
        @(negedge sclk);
        check_val("reset_rx_data", 32'(w_rx_data0), 32'h00);
        check_val("reset_rx_valid", 32'(w_rx_valid0), 32'h0);
        check_val("reset_frame_err", 32'(w_frame_err0), 32'h0);
        check_val("reset_busy", 32'(w_busy0), 32'h0);
        repeat (5) @(negedge sclk);

        // 1: single frame 0x55, start-edge to valid is 9.5 bits + 3 cycles
        v0 = r_v_cnt0; f0 = r_f_cnt0; q0n = r_q0.size();
        t0 = $time;
        send_frame(0, 8'h55, 10, 1'b1);
        repeat (5) @(negedge sclk);
        check_val("t1_valid_count", 32'(r_v_cnt0 - v0), 32'd1);
        check_val("t1_data", 32'(r_q0[q0n]), 32'h55);
        check_val("t1_frame_err", 32'(r_f_cnt0 - f0), 32'd0);
        check_val("t1_latency", 32'((r_v_time0 - t0) / c_PERIOD), 32'd98);
        check_val("t1_busy_idle", 32'(w_busy0), 32'h0);

        // 2: back-to-back frames, no idle gap
        v0 = r_v_cnt0; q0n = r_q0.size();
        send_frame(0, 8'hA3, 10, 1'b1);
        send_frame(0, 8'h0F, 10, 1'b1);
        repeat (5) @(negedge sclk);
        check_val("t2_valid_count", 32'(r_v_cnt0 - v0), 32'd2);
        check_val("t2_first", 32'(r_q0[q0n]), 32'hA3);
        check_val("t2_second", 32'(r_q0[q0n + 1]), 32'h0F);

        // 3: 3-cycle glitch
        v0 = r_v_cnt0; f0 = r_f_cnt0; b0 = r_busy_cyc0;
        drive_bit(0, 1'b0, 3);
        drive_bit(0, 1'b1, 20);
        check_val("t3_valid_count", 32'(r_v_cnt0 - v0), 32'd0);
        check_val("t3_frame_err", 32'(r_f_cnt0 - f0), 32'd0);
        check_val("t3_busy_cycles", 32'(r_busy_cyc0 - b0), 32'd5);
        check_val("t3_busy_idle", 32'(w_busy0), 32'h0);

        // 4: stop bit low, line held low, then recovery with 0x42
        v0 = r_v_cnt0; f0 = r_f_cnt0;
        send_frame(0, 8'h81, 10, 1'b0);
        drive_bit(0, 1'b0, 30);
        check_val("t4_frame_err", 32'(r_f_cnt0 - f0), 32'd1);
        check_val("t4_no_valid", 32'(r_v_cnt0 - v0), 32'd0);
        check_val("t4_data_held", 32'(w_rx_data0), 32'h0F);
        check_val("t4_busy_break", 32'(w_busy0), 32'h1);
        drive_bit(0, 1'b1, 10);
        check_val("t4_busy_released", 32'(w_busy0), 32'h0);
        q0n = r_q0.size();
        send_frame(0, 8'h42, 10, 1'b1);
        repeat (5) @(negedge sclk);
        check_val("t4_valid_count", 32'(r_v_cnt0 - v0), 32'd1);
        check_val("t4_data", 32'(r_q0[q0n]), 32'h42);

        // 5: reset during bit 4 of 0xF5; bits 4..7 and stop are high, so no later edge
        v0 = r_v_cnt0; f0 = r_f_cnt0;
        drive_bit(0, 1'b0, 10);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'(8'hF5 >> i), 10);
        drive_bit(0, 1'b1, 5);
        check_val("t5_busy_before_rst", 32'(w_busy0), 32'h1);
        r_rst = 1'b1;
        @(negedge sclk);
        check_val("t5_rst_busy", 32'(w_busy0), 32'h0);
        check_val("t5_rst_data", 32'(w_rx_data0), 32'h00);
        check_val("t5_rst_valid", 32'(w_rx_valid0), 32'h0);
        check_val("t5_rst_frame_err", 32'(w_frame_err0), 32'h0);
        r_rst = 1'b0;
        drive_bit(0, 1'b1, 4 + 40);
        check_val("t5_aborted_valid", 32'(r_v_cnt0 - v0), 32'd0);
        check_val("t5_aborted_ferr", 32'(r_f_cnt0 - f0), 32'd0);
        q0n = r_q0.size();
        send_frame(0, 8'h3C, 10, 1'b1);
        repeat (5) @(negedge sclk);
        check_val("t5_valid_count", 32'(r_v_cnt0 - v0), 32'd1);
        check_val("t5_data", 32'(r_q0[q0n]), 32'h3C);
        check_val("t5_data_port", 32'(w_rx_data0), 32'h3C);

        // 6: default divider 434, baud skew +2% (425 cyc/bit) and -2% (443 cyc/bit)
        v1 = r_v_cnt1; f1 = r_f_cnt1;
        send_frame(1, 8'hC5, 425, 1'b1);
        drive_bit(1, 1'b1, 500);
        send_frame(1, 8'hC5, 443, 1'b1);
        drive_bit(1, 1'b1, 500);
        check_val("t6_valid_count", 32'(r_v_cnt1 - v1), 32'd2);
        check_val("t6_fast_data", 32'(r_q1[0]), 32'hC5);
        check_val("t6_slow_data", 32'(r_q1[1]), 32'hC5);
        check_val("t6_frame_err", 32'(r_f_cnt1 - f1), 32'd0);
        check_val("t6_busy_idle", 32'(w_busy1), 32'h0);

        check_val("valid_and_ferr_together", 32'(r_both), 32'd0);

        $display("%0d/%0d checks passed", r_n_pass, r_n_checks);
        $finish;
    end

endmodule
`default_nettype wire
